// File: rtl/oport_alloc_if.sv
// oport_alloc_if: route requests, five input flit lanes, the forwarded output and credit return.
// Define OPORT_ALLOC_FLITCNT_EN to add the 16-bit accepted-flit counter flit_cnt.
interface oport_alloc_if;
    logic [4:0]  req;
    logic [39:0] in_flit;
    logic [4:0]  in_valid;
    logic [4:0]  in_ready;
    logic [7:0]  out_flit;
    logic        out_valid;
    logic        credit_in;
    logic [4:0]  grant;
`ifdef OPORT_ALLOC_FLITCNT_EN
    logic [15:0] flit_cnt;
    modport master (output req, in_flit, in_valid, credit_in,
                    input in_ready, out_flit, out_valid, grant, flit_cnt);
    modport slave  (input req, in_flit, in_valid, credit_in,
                    output in_ready, out_flit, out_valid, grant, flit_cnt);
`else
    modport master (output req, in_flit, in_valid, credit_in,
                    input in_ready, out_flit, out_valid, grant);
    modport slave  (input req, in_flit, in_valid, credit_in,
                    output in_ready, out_flit, out_valid, grant);
`endif
endinterface

// File: rtl/oport_alloc.sv
// oport_alloc: round-robin, packet-locked, credit-flow-controlled allocator for one output port.
// Define OPORT_ALLOC_FLITCNT_EN to add the wrapping 16-bit flit_cnt output.
module oport_alloc #(
    parameter int CREDITS = 4
) (
    input logic         clk,
    input logic         rst,
    oport_alloc_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t      r_state, w_next;
    logic [4:0]  r_grant, w_pick, w_elig, w_ready;
    logic [2:0]  r_ptr, r_cred, w_gidx;
    logic [7:0]  r_out_flit, w_sel;
    logic        r_out_valid, w_acc, w_tail;

    always_comb begin
        w_elig = '0;
        w_sel  = '0;
        w_gidx = '0;
        for (int i = 0; i < 5; i++) begin
            w_elig[i] = bus.req[i] & bus.in_valid[i] & (bus.in_flit[8*i+6 +: 2] == 2'b10);
            if (r_grant[i]) begin
                w_sel  = bus.in_flit[8*i +: 8];
                w_gidx = 3'(i);
            end
        end
    end

    // Scan from the farthest candidate back to ptr so the first eligible one after ptr wins.
    always_comb begin
        w_pick = '0;
        for (int k = 4; k >= 0; k--)
            if (w_elig[3'((int'(r_ptr) + k) % 5)])
                w_pick = 5'(1) << 3'((int'(r_ptr) + k) % 5);
    end

    assign w_ready = (r_state == LOCKED && r_cred != 3'd0) ? r_grant : 5'd0;
    assign w_acc   = |(bus.in_valid & w_ready);
    assign w_tail  = w_sel[7:6] == 2'b01;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = |w_elig ? LOCKED : IDLE;
        else
            w_next = (w_acc && w_tail) ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_out_valid <= w_acc;
            if (w_acc)
                r_out_flit <= w_sel;
            if (r_state == IDLE)
                r_grant <= w_pick;
            else if (w_acc && w_tail) begin
                r_grant <= '0;
                r_ptr   <= (w_gidx == 3'd4) ? 3'd0 : w_gidx + 3'd1;
            end
        end
    end

    // Simultaneous accept and credit return cancel out; a return at full depth is dropped.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cred <= 3'(CREDITS);
        else if (w_acc && !bus.credit_in)
            r_cred <= r_cred - 3'd1;
        else if (!w_acc && bus.credit_in && r_cred != 3'(CREDITS))
            r_cred <= r_cred + 3'd1;

`ifdef OPORT_ALLOC_FLITCNT_EN
    logic [15:0] r_flit_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_flit_cnt <= '0;
        else     r_flit_cnt <= r_flit_cnt + 16'(w_acc);
    assign bus.flit_cnt = r_flit_cnt;
`endif

    assign bus.in_ready  = w_ready;
    assign bus.grant     = r_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_flit  = r_out_flit;
endmodule

// File: tb/tb_oport_alloc.sv
// tb_oport_alloc: scoreboard bench for oport_alloc; covers arbitration order, credits and async reset.
// Define OPORT_ALLOC_FLITCNT_EN to also exercise flit_cnt.
module tb_oport_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oport_alloc_if bus();
    oport_alloc #(.CREDITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_chk = 0, n_pass = 0;
    logic [7:0] sb[$];
    logic [7:0] pk[5][8];
    int         pn[5], pi[5];
    int         fwd, n_acc, cr_pend, cr_at_acc;
    bit         auto_cr;
    logic [4:0] glog[$];
    logic [4:0] last_g;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] fl(input int p, input int i);
        return (i < 8) ? pk[p][i] : 8'h00;
    endfunction

    function automatic bit done();
        for (int p = 0; p < 5; p++) if (pi[p] < pn[p]) return 1'b0;
        return 1'b1;
    endfunction

    // Downstream side: every forwarded flit must be the oldest accepted one.
    always @(negedge clk)
        if (!rst && bus.out_valid) begin
            fwd++;
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 1);
            else check("out_flit", bus.out_flit, sb.pop_front());
        end

    task automatic tick();
        logic [4:0] acc;
        for (int p = 0; p < 5; p++) begin
            bus.req[p]            = pi[p] < pn[p];
            bus.in_valid[p]       = pi[p] < pn[p];
            bus.in_flit[8*p +: 8] = fl(p, pi[p]);
        end
        #1;
        acc = bus.in_valid & bus.in_ready;
        bus.credit_in = (auto_cr && bus.out_valid) || cr_pend > 0 || (acc != 0 && n_acc == cr_at_acc);
        if (cr_pend > 0) cr_pend--;
        for (int p = 0; p < 5; p++)
            if (acc[p]) begin
                sb.push_back(fl(p, pi[p]));
                pi[p]++;
                n_acc++;
            end
        @(posedge clk);
        #1;
        bus.credit_in = 1'b0;
        if (bus.grant != 0 && bus.grant != last_g) glog.push_back(bus.grant);
        last_g = bus.grant;
    endtask

    task automatic run(input int lim);
        for (int t = 0; t < lim && !done(); t++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.in_valid = '0; bus.in_flit = '0; bus.credit_in = 1'b0;
        for (int p = 0; p < 5; p++) begin pn[p] = 0; pi[p] = 0; end
        sb.delete(); glog.delete();
        fwd = 0; n_acc = 0; cr_pend = 0; cr_at_acc = -1; auto_cr = 1'b1; last_g = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_pkt(input int p, input logic [63:0] f, input int n);
        for (int i = 0; i < 8; i++) pk[p][i] = f[63-8*i -: 8];
        pn[p] = n;
        pi[p] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req = '0; bus.in_valid = '0; bus.in_flit = '0; bus.credit_in = 1'b0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_flit", bus.out_flit, 0);
        check("rst_in_ready", bus.in_ready, 0);
        do_reset();

        // Single three-flit packet on input 0
        set_pkt(0, 64'h85_05_45_00_00_00_00_00, 3);
        tick();
        check("p0_grant", bus.grant, 5'b00001);
        run(10);
        check("p0_done", pi[0], 3);
        check("p0_grant_clear", bus.grant, 0);
        tick();
        check("p0_fwd", fwd, 3);
        check("p0_idle_valid", bus.out_valid, 0);
        check("p0_hold_flit", bus.out_flit, 8'h45);
        // ptr must now be 1, so input 1 beats input 0
        glog.delete();
        set_pkt(0, 64'h80_40_00_00_00_00_00_00, 2);
        set_pkt(1, 64'h81_41_00_00_00_00_00_00, 2);
        tick();
        check("ptr1_grant", bus.grant, 5'b00010);
        run(20);
        check("ptr1_done", pi[0] + pi[1], 4);
        check("ptr1_second", glog.size() > 1 ? glog[1] : 5'd0, 5'b00001);

        // Inputs 0 and 3 contend; input 0 has a second packet held behind its first
        do_reset();
        set_pkt(0, 64'h80_00_40_82_00_40_00_00, 6);
        set_pkt(3, 64'h83_03_43_00_00_00_00_00, 3);
        run(60);
        check("rr_done", pi[0] + pi[3], 9);
        check("rr_nlog", glog.size(), 3);
        check("rr_first", glog.size() > 0 ? glog[0] : 5'd0, 5'b00001);
        check("rr_second", glog.size() > 1 ? glog[1] : 5'd0, 5'b01000);
        check("rr_third", glog.size() > 2 ? glog[2] : 5'd0, 5'b00001);
        tick();
        check("rr_fwd", fwd, 9);

        // Credit stall: extra credits at full depth are dropped, so only 4 flits go out
        do_reset();
        auto_cr = 1'b0;
        cr_pend = 2;
        repeat (3) tick();
        set_pkt(0, 64'h80_00_00_00_00_40_00_00, 6);
        run(20);
        check("cr_stall_acc", pi[0], 4);
        check("cr_stall_fwd", fwd, 4);
        check("cr_stall_ready", bus.in_ready, 0);
        check("cr_stall_grant", bus.grant, 5'b00001);
        cr_pend = 2;
        run(20);
        check("cr_resume_acc", pi[0], 6);
        tick();
        check("cr_resume_fwd", fwd, 6);
        check("cr_resume_grant", bus.grant, 0);

        // Credit return coincident with the accept at count 2 keeps the count at 2
        do_reset();
        auto_cr = 1'b0;
        cr_at_acc = 2;
        set_pkt(0, 64'h80_00_00_00_00_00_00_40, 8);
        run(30);
        check("cr_same_acc", pi[0], 5);
        check("cr_same_fwd", fwd, 5);

        // Async reset mid-packet, between clock edges
        do_reset();
        set_pkt(0, 64'h80_11_22_40_00_00_00_00, 4);
        repeat (3) tick();
        check("ar_pre_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_grant", bus.grant, 0);
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_out_flit", bus.out_flit, 0);
        do_reset();
        set_pkt(2, 64'h82_02_42_00_00_00_00_00, 3);
        tick();
        check("ar_new_grant", bus.grant, 5'b00100);
        run(10);
        check("ar_new_done", pi[2], 3);
        tick();
        check("ar_new_fwd", fwd, 3);

`ifdef OPORT_ALLOC_FLITCNT_EN
        do_reset();
        check("fc_rst", bus.flit_cnt, 0);
        set_pkt(0, 64'h85_05_45_00_00_00_00_00, 3);
        run(10);
        check("fc_three", bus.flit_cnt, 3);
        set_pkt(0, 64'h80_00_00_00_00_00_00_00, 65532);
        run(70000);
        check("fc_max", bus.flit_cnt, 16'hFFFF);
        pn[0] = 65533;
        run(5);
        check("fc_wrap", bus.flit_cnt, 0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
